// File: rtl/pipearch_region_pkg.sv
// Shared types for the region read path: the read mode, the
// rfifobram select encodings and the stream reader state enum.
package pipearch_region_pkg;

    typedef enum logic {
        REGION_BRAM = 1'b0,
        REGION_FIFO = 1'b1
    } region_mode_t;

    localparam logic [1:0] RFB_BRAM = 2'b01;
    localparam logic [1:0] RFB_FIFO = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2
    } reader_state_t;

    function automatic logic [1:0] rfb_encode(region_mode_t m);
        return (m == REGION_FIFO) ? RFB_FIFO : RFB_BRAM;
    endfunction

endpackage

// File: rtl/region_stream_reader_stream_out_fifo.sv
// stream_out_fifo: synchronous FWFT buffer, depth 2**LOG2_DEPTH.
// Ports: clk, reset (async, active-low), push/push_data, pop, head_data, count.
module stream_out_fifo #(
    parameter int WIDTH      = 512,
    parameter int LOG2_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic [LOG2_DEPTH:0] count
);
    localparam int AW = LOG2_DEPTH;
    localparam int CW = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** LOG2_DEPTH);

    logic [WIDTH-1:0] mem [2 ** LOG2_DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    // A push into a full buffer is accepted only alongside a pop.
    assign do_push = push && ((cnt_q != DEPTH) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_data = mem[rd_q];
    assign count     = cnt_q;

endmodule

// File: rtl/region_stream_reader.sv
// region_stream_reader: drains one region read channel (BRAM or FIFO) into a
// valid/ready stream. Ports: start/mode/base_addr/num_lines command, busy/done
// status, re/rfifobram/raddr + rvalid/rdata/empty region side, out_* stream.
// Optional stall_cycles counter with REGION_STREAM_READER_STATS_EN defined.
module region_stream_reader
    import pipearch_region_pkg::*;
#(
    parameter int WIDTH          = 512,
    parameter int LOG2_DEPTH     = 9,
    parameter int OUT_LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [LOG2_DEPTH-1:0] base_addr,
    input  logic [LOG2_DEPTH:0]   num_lines,
    output logic                  busy,
    output logic                  done,
    output logic                  re,
    output logic [1:0]            rfifobram,
    output logic [LOG2_DEPTH-1:0] raddr,
    input  logic                  rvalid,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  empty,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    input  logic                  out_ready
`ifdef REGION_STREAM_READER_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int CW = OUT_LOG2_DEPTH + 1;
    localparam int NW = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] FULL_CREDITS = CW'(2 ** OUT_LOG2_DEPTH);

    reader_state_t         state_q, state_d;
    region_mode_t          mode_q, mode_eff;
    logic [LOG2_DEPTH-1:0] base_q, base_eff, raddr_q;
    logic [NW-1:0]         nl_q, issued_q, issued_eff;
    logic [NW-1:0]         received_q, popped_q;
    logic [CW-1:0]         credits_q, credits_avail, fifo_count;
    logic [1:0]            rfb_q;
    logic                  re_q, done_q, done_d;
    logic                  take, issue, push, pop, last_beat;

    stream_out_fifo #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (OUT_LOG2_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rdata),
        .pop       (pop),
        .head_data (out_data),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = rvalid && (state_q != RD_IDLE);
    assign out_last  = out_valid && (state_q != RD_IDLE)
                     && (popped_q == nl_q - NW'(1));
    assign last_beat = pop && out_last;

    // A slot freed this cycle can already back the next read.
    assign credits_avail = credits_q + CW'(pop);

    assign mode_eff   = take ? region_mode_t'(mode) : mode_q;
    assign base_eff   = take ? base_addr : base_q;
    assign issued_eff = take ? '0 : issued_q;

    // issue decides the read presented on re in the NEXT cycle. In FIFO mode
    // a read is never decided while one is on the bus: the current empty
    // does not yet reflect that pop, so back-to-back could underflow.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        issue   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (start) begin
                    take = 1'b1;
                    if (num_lines == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RD_ISSUE;
                        issue   = !mode || !empty;
                    end
                end
            end
            RD_ISSUE: begin
                if (issued_q == nl_q) begin
                    state_d = RD_DRAIN;
                end else begin
                    issue = (credits_avail != '0)
                          && ((mode_q == REGION_BRAM) || (!empty && !re_q));
                end
            end
            RD_DRAIN: begin
                if (last_beat && (received_q == nl_q)) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RD_IDLE;
            mode_q     <= REGION_BRAM;
            base_q     <= '0;
            nl_q       <= '0;
            issued_q   <= '0;
            received_q <= '0;
            popped_q   <= '0;
            credits_q  <= FULL_CREDITS;
            re_q       <= 1'b0;
            rfb_q      <= '0;
            raddr_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            re_q      <= issue;
            credits_q <= credits_q + CW'(pop) - CW'(issue);
            issued_q  <= issued_eff + NW'(issue);
            rfb_q     <= (state_d == RD_ISSUE) ? rfb_encode(mode_eff) : 2'b00;
            if (issue) begin
                raddr_q <= (mode_eff == REGION_FIFO) ? '0
                         : base_eff + issued_eff[LOG2_DEPTH-1:0];
            end
            if (take) begin
                mode_q     <= mode_eff;
                base_q     <= base_addr;
                nl_q       <= num_lines;
                received_q <= '0;
                popped_q   <= '0;
            end else begin
                received_q <= received_q + NW'(push);
                popped_q   <= popped_q + NW'(pop);
            end
        end
    end

    assign busy      = (state_q != RD_IDLE);
    assign done      = done_q;
    assign re        = re_q;
    assign rfifobram = rfb_q;
    assign raddr     = raddr_q;

`ifdef REGION_STREAM_READER_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (take) begin
            stall_q <= '0;
        end else if (busy && out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    // Responses still in flight when reset hit may land shortly after
    // release; they are dropped silently for a few cycles.
    logic [2:0] grace_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grace_q <= '0;
        end else if (grace_q != 3'd7) begin
            grace_q <= grace_q + 3'd1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (fifo_count == FULL_CREDITS)));

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!reset)
        !(rvalid && (state_q == RD_IDLE) && (grace_q == 3'd7)));

endmodule

// File: tb/tb_region_stream_reader.sv
// Directed + randomized bench for region_stream_reader against a
// behavioural region (BRAM array / FIFO queue, latency 1) and stream model.
module tb_region_stream_reader;
    import pipearch_region_pkg::*;

    localparam int W   = 32;
    localparam int LD  = 5;
    localparam int NLW = LD + 1;
    localparam int OLD = 2;
    localparam int RDEPTH = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           mode;
    logic [LD-1:0]  base_addr;
    logic [LD:0]    num_lines;
    logic           busy, done, re;
    logic [1:0]     rfifobram;
    logic [LD-1:0]  raddr;
    logic           rvalid = 1'b0;
    logic [W-1:0]   rdata = '0;
    logic           empty;
    logic           out_valid, out_last;
    logic [W-1:0]   out_data;
    logic           out_ready;
`ifdef REGION_STREAM_READER_STATS_EN
    logic [31:0]    stall_cycles;
`endif

    logic [W-1:0] bram [RDEPTH];
    logic [W-1:0] rq[$];
    logic [W-1:0] fifo_exp[$];
    int           addr_log[$];
    int           pushed_n = 0;
    int           popped_n = 0;
    int           viol = 0;
    logic         inj = 1'b0;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    region_stream_reader #(
        .WIDTH          (W),
        .LOG2_DEPTH     (LD),
        .OUT_LOG2_DEPTH (OLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .busy      (busy),
        .done      (done),
        .re        (re),
        .rfifobram (rfifobram),
        .raddr     (raddr),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .empty     (empty),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef REGION_STREAM_READER_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign empty = (pushed_n == popped_n);

    always @(posedge clk) begin
        rvalid <= 1'b0;
        if (inj) begin
            rvalid <= 1'b1;
            rdata  <= 32'hDEAD_BEEF;
        end else if (re && rfifobram == RFB_BRAM) begin
            rvalid <= 1'b1;
            rdata  <= bram[raddr];
            addr_log.push_back(int'(raddr));
        end else if (re && rfifobram == RFB_FIFO) begin
            if (empty) begin
                viol <= viol + 1;
            end else begin
                rvalid   <= 1'b1;
                rdata    <= rq.pop_front();
                popped_n <= popped_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_re"}, re, 0);
        chk({tag, "_rfb"}, rfifobram, 0);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_ovalid"}, out_valid, 0);
        chk({tag, "_olast"}, out_last, 0);
`ifdef REGION_STREAM_READER_STATS_EN
        chk({tag, "_stall"}, stall_cycles, 0);
`endif
    endtask

    task automatic push_gaps();
        for (int i = 0; i < fifo_exp.size(); i++) begin
            repeat ($urandom_range(5, 2)) @(posedge clk);
            #1;
            rq.push_back(fifo_exp[i]);
            pushed_n++;
        end
    endtask

    // Called and returns at posedge+#1. The expected stream is built from
    // the region contents before the transfer begins.
    task automatic do_xfer(input bit m, input int base, input int n,
                           input int pct, input int stall_at,
                           input int restart_at, input bit gapless,
                           input string tag);
        logic [W-1:0] exp_d[$];
        int           exp_a[$];
        logic [W-1:0] got_d[$];
        logic         got_l[$];
        int s_cyc, first_hs, last_hs, dcyc, nre, max_in, nlast;
        bit fin;
        first_hs = -1; last_hs = -1; dcyc = -1;
        nre = 0; max_in = 0; nlast = 0; fin = 0;
        if (m) begin
            exp_d = fifo_exp;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_a.push_back((base + i) % RDEPTH);
                exp_d.push_back(bram[(base + i) % RDEPTH]);
            end
        end
        addr_log.delete();
        mode      = m;
        base_addr = LD'(base);
        num_lines = NLW'(n);
        start     = 1'b1;
        s_cyc     = cyc;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (k > 0) start = (k == restart_at);
            if (k == restart_at) begin
                num_lines = NLW'(3);
                base_addr = '0;
                mode      = !m;
            end
            if (k >= stall_at && k < stall_at + 20) out_ready = 1'b0;
            else out_ready = (int'($urandom_range(99)) < pct);
            @(negedge clk);
            if (re) nre++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (nre - got_d.size() > max_in) max_in = nre - got_d.size();
            if (done) begin
                fin  = 1;
                dcyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        @(posedge clk);
        #1;
        chk({tag, "_timeout"}, fin, 1);
        chk({tag, "_beats"}, got_d.size(), n);
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        foreach (got_l[i]) if (got_l[i]) nlast++;
        chk({tag, "_last_count"}, nlast, (n > 0) ? 1 : 0);
        if (n > 0 && got_l.size() == n)
            chk({tag, "_last_pos"}, got_l[n-1], 1);
        if (!m) begin
            chk({tag, "_addr_count"}, addr_log.size(), n);
            for (int i = 0; i < addr_log.size() && i < exp_a.size(); i++)
                chk($sformatf("%s_addr%0d", tag, i), addr_log[i], exp_a[i]);
        end
        chk({tag, "_done_time"}, dcyc, (n == 0) ? s_cyc + 1 : last_hs + 1);
        chk({tag, "_inflight"}, max_in <= 4, 1);
        if (n == 0) chk({tag, "_no_re"}, nre, 0);
        if (gapless) chk({tag, "_gapless"}, last_hs - first_hs, n - 1);
    endtask

    initial begin
        int bad;
        reset     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        base_addr = '0;
        num_lines = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 0; a < RDEPTH; a++) bram[a] = W'(a);
        do_xfer(0, 'h10, 8, 100, 1000, -1, 1, "bram8");

        for (int a = 0; a < RDEPTH; a++) bram[a] = $urandom;
        do_xfer(0, 30, 4, 100, 1000, -1, 0, "wrap");

        fifo_exp.delete();
        for (int i = 0; i < 5; i++) fifo_exp.push_back($urandom);
        fork
            do_xfer(1, 0, 5, 100, 1000, -1, 0, "fifo5");
            push_gaps();
        join
        chk("fifo_re_while_empty", viol, 0);

        for (int a = 0; a < RDEPTH; a++) bram[a] = $urandom;
        do_xfer(0, int'($urandom_range(31)), 16, 100, 6, -1, 0, "bp");
`ifdef REGION_STREAM_READER_STATS_EN
        chk("bp_stall_cycles", stall_cycles, 20);
`endif

        do_xfer(0, 0, 0, 100, 1000, -1, 0, "zero");
        do_xfer(0, 3, 8, 80, 1000, 4, 0, "restart");

        for (int a = 0; a < RDEPTH; a++) bram[a] = $urandom;
        mode      = 1'b0;
        base_addr = LD'(5);
        num_lines = NLW'(16);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk);
        #1 reset = 1'b1;
        inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || busy || re) bad++;
        end
        @(posedge clk);
        #1;
        chk("post_reset_quiet", bad, 0);
        do_xfer(0, int'($urandom_range(31)), 10, 100, 1000, -1, 1, "after_rst");

        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < RDEPTH; a++) bram[a] = $urandom;
            do_xfer(0, int'($urandom_range(31)), int'($urandom_range(20, 1)),
                    int'($urandom_range(100, 40)), 1000, -1, 0,
                    $sformatf("rnd%0d", t));
        end

        fifo_exp.delete();
        for (int i = 0; i < int'($urandom_range(8, 1)); i++)
            fifo_exp.push_back($urandom);
        fork
            do_xfer(1, 0, fifo_exp.size(), 70, 1000, -1, 0, "rnd_fifo");
            push_gaps();
        join
        chk("rnd_fifo_re_while_empty", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/region_stream_reader.md
# region_stream_reader

Drains one read channel of the replicated BRAM/FIFO region and presents its contents as a valid/ready stream. It sits directly downstream of the region replicator: one instance per read channel, feeding a compute pipeline lane. On `start` it reads `num_lines` entries, either from BRAM addresses `base_addr` upward or by popping the region FIFO. It absorbs the region's fixed read latency with a credit-tracked output buffer, so downstream backpressure never drops data.

## Interface
- `WIDTH`, 512: data width in bits; must match the region.
- `LOG2_DEPTH`, 9: region address width.
- `OUT_LOG2_DEPTH`, 2: log2 of the output buffer depth (4 entries).
- `clk`  in  1: clock.
- `reset`  in  1: one clock; reset is asynchronous and active-low.
- `start`  in  1: single-cycle pulse; sampled only in IDLE.
- `mode`  in  1: 0 = BRAM, 1 = FIFO; latched at `start`.
- `base_addr`  in  LOG2_DEPTH: first BRAM address; latched at `start`.
- `num_lines`  in  LOG2_DEPTH+1: lines to read; latched at `start`.
- `busy`  out  1: high from the cycle after `start` until `done`.
- `done`  out  1: single-cycle pulse when the last line is accepted downstream.
- `re`  out  1: region read enable.
- `rfifobram`  out  2: 2'b01 selects BRAM, 2'b10 selects FIFO.
- `raddr`  out  LOG2_DEPTH: BRAM read address.
- `rvalid`  in  1: region read response valid.
- `rdata`  in  WIDTH: region read data.
- `empty`  in  1: region FIFO empty.
- `out_valid`, `out_data` [WIDTH], `out_last`  out: downstream stream.
- `out_ready`  in  1: downstream accept.
- `stall_cycles`  out  32: present only with the `_EN` macro (see Configuration).

## Operation
- FSM states:
  - IDLE: `start` latches the inputs and moves to ISSUE. If `num_lines`==0, go straight to IDLE and pulse `done` next cycle.
  - ISSUE: issue reads until `issued`==`num_lines`, then go to DRAIN.
  - DRAIN: wait until `received`==`num_lines` and the buffer is empty; pulse `done`, return to IDLE.
- Issue condition, evaluated each cycle in ISSUE: `issued` < `num_lines` AND `credits` > 0 AND (mode==0 OR `empty`==0).
- Credits: `credits` = buffer free slots − in-flight reads. Increment on buffer pop; decrement on issue. Simultaneous issue and pop leaves `credits` unchanged.
- BRAM mode: `raddr` = `base_addr` + `issued`, modulo 2^LOG2_DEPTH; wraps silently.
- FIFO mode: `raddr` is don't-care (driven to 0).
- Every `rvalid` pushes `rdata` into the buffer. Credits guarantee the buffer never overflows; an overflow is an assertion failure.
- `rvalid` outside ISSUE/DRAIN is ignored and flagged by assertion.
- `out_last` is high on the head entry when the number of popped entries equals `num_lines`−1.
- `start` while busy is ignored.
- Reset asserted mid-transfer: all state is cleared immediately. In-flight responses arriving after reset deasserts are dropped, because the FSM is in IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `re`=0, `rfifobram`=0, `raddr`=0, `out_valid`=0, `out_last`=0, counters and credits at their empty/full values, `stall_cycles`=0.
- `re`, `rfifobram` and `raddr` are registered and assert in the first ISSUE cycle, one cycle after `start`.
- Full throughput: one read per cycle when credits allow. With a region latency of L cycles, sustained rate is 1 line/cycle if buffer depth ≥ L+1.
- `out_valid` rises the cycle after the first `rvalid` (buffer write latency 1). A transfer occurs when `out_valid` and `out_ready` are both high.
- `done` is asserted the cycle after the final handshake.

## Configuration
- `REGION_STREAM_READER_STATS_EN`:
  - Defined: `stall_cycles` port exists. It counts cycles in ISSUE/DRAIN with `out_valid`=1 and `out_ready`=0, clears at `start`, and saturates at 2^32−1.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- `pipearch_region_pkg` holds:
  - `region_mode_t` (REGION_BRAM, REGION_FIFO);
  - the `rfifobram` encodings `RFB_BRAM`=2'b01 and `RFB_FIFO`=2'b10;
  - the reader state enum.
- One sub-module, `stream_out_fifo`: a synchronous FIFO of depth 2^OUT_LOG2_DEPTH with push, pop, count and first-word-fall-through head. The FSM, counters and credit logic live in the top.

## Test plan
- BRAM mode, `base_addr`=0x10, `num_lines`=8, `out_ready`=1, region preloaded with data = addr → 8 beats with data 0x10..0x17, `out_last` on beat 8, `done` one cycle later, no idle beats after the first.
- BRAM wrap, `LOG2_DEPTH`=4, `base_addr`=14, `num_lines`=4 → addresses 14, 15, 0, 1 issued in order.
- FIFO mode, 5 lines pushed with gaps so `empty` toggles, `num_lines`=5 → `re` never asserted while `empty`=1, 5 beats in push order, `done` pulses.
- Backpressure: `out_ready`=0 for 20 cycles mid-transfer → at most 4 reads in flight plus buffered, no loss or duplication, and with the macro defined `stall_cycles`=20.
- `num_lines`=0 → `done` one cycle after `start`, no `re`; a second `start` while busy is ignored.
- Reset pulsed during ISSUE of a 16-line transfer, late `rvalid` after release → all outputs at reset values, no `out_valid`, next transfer is correct.
